// File: rtl/vx_nc_mmio_responder.sv
// vx_nc_mmio_responder: MMIO register bank behind the NC bypass, serving single-word
// reads and writes with tag-echoed, in-order read responses and credit-based flow control.
module vx_nc_mmio_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DATA_SIZE = 16,
  parameter int TAG_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'hFF000000,
  parameter int NUM_REGS = 16,
  parameter int RSP_LATENCY = 2,
  parameter int RSP_QUEUE_SIZE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_req_valid,
  input  logic                       mem_req_rw,
  input  logic [ADDR_WIDTH-1:0]      mem_req_addr,
  input  logic [MEM_DATA_SIZE-1:0]   mem_req_byteen,
  input  logic [MEM_DATA_SIZE*8-1:0] mem_req_data,
  input  logic [TAG_WIDTH-1:0]       mem_req_tag,
  output logic                       mem_req_ready,
  output logic                       mem_rsp_valid,
  output logic [MEM_DATA_SIZE*8-1:0] mem_rsp_data,
  output logic [TAG_WIDTH-1:0]       mem_rsp_tag,
  input  logic                       mem_rsp_ready,
  output logic [NUM_REGS*32-1:0]     regs_out,
  output logic                       err_out
);
  localparam int LW = MEM_DATA_SIZE > 4 ? $clog2(MEM_DATA_SIZE) - 2 : 1;
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int PW = RSP_QUEUE_SIZE > 1 ? $clog2(RSP_QUEUE_SIZE) : 1;
  localparam int CW = $clog2(RSP_QUEUE_SIZE) + 1;
  localparam int SL = RSP_LATENCY > 1 ? RSP_LATENCY - 1 : 1;
  localparam int PI = RSP_LATENCY > 1 ? RSP_LATENCY - 2 : 0;
  typedef struct packed {
    logic [31:0]          w;
    logic [LW-1:0]        l;
    logic [TAG_WIDTH-1:0] t;
  } ent_t;
  logic [31:0] regs [NUM_REGS];
  logic [CW-1:0] credits, cnt;
  logic [ADDR_WIDTH-1:0] off;
  logic [LW-1:0] lane;
  logic [IW-1:0] idx;
  logic [31:0] wdata;
  logic [3:0] wbe;
  logic in_win, acc, rd_acc, pop, push;
  ent_t in_e, push_e, head;
  ent_t stg [SL];
  logic stg_v [SL];
  ent_t fifo [RSP_QUEUE_SIZE];
  logic [PW-1:0] wptr, rptr;
  assign off = mem_req_addr - BASE_ADDR;
  assign in_win = off < ADDR_WIDTH'(4 * NUM_REGS);
  assign idx = off[2 +: IW];
  assign lane = MEM_DATA_SIZE > 4 ? mem_req_addr[2 +: LW] : '0;
  assign wdata = mem_req_data[32 * lane +: 32];
  assign wbe = mem_req_byteen[4 * lane +: 4];
  assign mem_req_ready = !reset && credits != '0;
  assign acc = mem_req_valid && mem_req_ready;
  assign rd_acc = acc && !mem_req_rw;
  assign pop = mem_rsp_valid && mem_rsp_ready;
  assign in_e = '{w: in_win ? regs[idx] : 32'h0, l: lane, t: mem_req_tag};
  // the registered FIFO slot is the last latency stage, so only RSP_LATENCY-1 shift stages precede it
  assign push = RSP_LATENCY == 1 ? rd_acc : stg_v[PI];
  assign push_e = RSP_LATENCY == 1 ? in_e : stg[PI];
  assign head = fifo[rptr];
  assign mem_rsp_valid = cnt != '0;
  assign mem_rsp_tag = head.t;
  assign mem_rsp_data = (MEM_DATA_SIZE*8)'(head.w) << (32 * head.l);
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (acc && mem_req_rw && in_win)
      for (int b = 0; b < 4; b++) if (wbe[b]) regs[idx][8*b +: 8] <= wdata[8*b +: 8];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      credits <= CW'(RSP_QUEUE_SIZE);
      err_out <= 1'b0;
    end else begin
      if (acc && !in_win) err_out <= 1'b1;
      if (rd_acc && !pop) credits <= credits - 1'b1;
      else if (pop && !rd_acc) credits <= credits + 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < SL; i++) begin
        stg[i] <= '0;
        stg_v[i] <= 1'b0;
      end
    else begin
      stg[0] <= in_e;
      stg_v[0] <= rd_acc;
      for (int i = 1; i < SL; i++) begin
        stg[i] <= stg[i-1];
        stg_v[i] <= stg_v[i-1];
      end
    end
  // credits pre-count everything in flight, so a push never finds the FIFO full after the pop
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < RSP_QUEUE_SIZE; i++) fifo[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        fifo[wptr] <= push_e;
        wptr <= wptr == PW'(RSP_QUEUE_SIZE - 1) ? '0 : wptr + 1'b1;
      end
      if (pop) rptr <= rptr == PW'(RSP_QUEUE_SIZE - 1) ? '0 : rptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_out[32*g +: 32] = regs[g];
  end
endmodule
